prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream program loader: the writer side of the 9-bit instruction ROM that
//  the PC/fetch path reads. Accepts a framed program image over a valid/ready byte
//  interface, packs byte pairs into 9-bit instructions and writes them to ROM
//  addresses 0..N-1. Holds the core in init (core_start high) until the image
//  checksum verifies, then releases it to run.
// PARAMETERS
//  AW           10  ROM address width (matches PC width); max image 2**AW words
//  IW            9  instruction width
//  START_CYCLES  2  cycles core_start stays high after checksum passes (>=1)
// PORTS
//  CLK        in   1      clock, posedge
//  reset_n    in   1      asynchronous reset, active low
//  rx_data    in   8      stream byte
//  rx_valid   in   1      rx_data valid
//  rx_ready   out  1      loader accepts byte; transfer = rx_valid & rx_ready
//  halt       in   1      done flag from core; permits reload while in RUN
//  rom_we     out  1      ROM write strobe, one cycle per instruction
//  rom_addr   out  AW     ROM write address
//  rom_wdata  out  IW     ROM write data
//  core_start out  1      core init, active high (drives core start)
//  busy       out  1      frame in progress (HDR_HI..RELEASE)
//  done       out  1      image loaded and verified, core released
//  err        out  1      frame error, sticky until reset_n
//  err_code   out  2      1=count too large, 2=bad high byte, 3=checksum mismatch
// BEHAVIOUR
//  Frame: CNT_LO, CNT_HI (N, 16-bit LE), then N x {INS_LO, INS_HI}, then CHK.
//   Instruction = {INS_HI[0], INS_LO}. CHK = XOR of every preceding frame byte.
//  Reset (async): state=HDR_LO, core_start=1, rom_we=0, rom_addr=0, rom_wdata=0,
//   done=0, busy=0, err=0, err_code=0, checksum=0, word counter=0.
//  rx_ready (combinational): 1 in HDR_LO/HDR_HI/INS_LO/INS_HI/CHK; =halt in RUN;
//   0 in RELEASE and ERR. Every accepted byte except CHK XORs into checksum.
//  FSM (advances only on transfer unless noted):
//   HDR_LO : latch N[7:0]                                  -> HDR_HI
//   HDR_HI : latch N[15:8]; N>2**AW -> ERR(1); N==0 -> CHK; else -> INS_LO
//   INS_LO : latch low byte                                -> INS_HI
//   INS_HI : byte[7:1]!=0 -> ERR(2), no write; else rom_we=1 next cycle with
//            rom_addr=word index, rom_wdata=packed word; index+1;
//            index==N-1 -> CHK else -> INS_LO
//   CHK    : byte==checksum -> RELEASE (counter=START_CYCLES); else ERR(3)
//   RELEASE: no transfer; core_start=1; counter-- each cycle; at 0 -> RUN,
//            core_start=0 and done=1 on entry to RUN
//   RUN    : core_start=0; transfer (only when halt=1) = new CNT_LO: latch N[7:0],
//            checksum=byte, index=0, done=0, core_start=1 next cycle -> HDR_HI
//   ERR    : core_start=1, err=1, err_code held; ignores stream; exit only by reset_n
//  rom_we is registered: write lands 1 cycle after INS_HI transfer; max one write
//   per 2 transfers, so no write back-pressure. rom_addr/rom_wdata hold last value.
//  busy=1 in HDR_HI, INS_LO, INS_HI, CHK, RELEASE; 0 in HDR_LO, RUN, ERR.
//  N==2**AW legal: last write at address 2**AW-1; index never wraps.
//  Earlier ROM writes are not undone on ERR; core stays in init.
//  reset_n mid-frame: all state cleared; partial image left in ROM; restart at HDR_LO.
//  rx_valid held low: FSM waits indefinitely in any receiving state, outputs held.
// TESTING
//  1 reset_n low then high -> core_start=1, rx_ready=1, done=0, rom_we=0, err=0.
//  2 stream 02 00 A5 01 3C 00 CHK=9A -> writes addr0=0x1A5, addr1=0x03C; core_start
//    high for 2 cycles after CHK transfer, then 0; done=1.
//  3 stream 01 00 11 02 .. -> no write, err=1, err_code=2, rx_ready=0, core_start=1.
//  4 stream 01 04 (N=1025, AW=10) -> err_code=1, no writes.
//  5 stream 00 00 00 (N=0, CHK=00) -> no writes, done=1; CHK=FF instead -> err_code=3.
//  6 after test 2 hold halt=0: rx_ready=0; raise halt, send new frame -> done drops,
//    core_start reasserts, new image written; toggle rx_valid randomly -> same result.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: unpacks a framed, checksummed image into the 9-bit
// instruction ROM and holds the core in init until the image verifies.
module prog_loader #(
  parameter int AW           = 10,
  parameter int IW           = 9,
  parameter int START_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic          halt,
  output logic          rom_we,
  output logic [AW-1:0] rom_addr,
  output logic [IW-1:0] rom_wdata,
  output logic          core_start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int RW = (START_CYCLES < 2) ? 1 : $clog2(START_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << AW;

  typedef enum logic [2:0] {
    S_HDR_LO  = 3'd0,
    S_HDR_HI  = 3'd1,
    S_INS_LO  = 3'd2,
    S_INS_HI  = 3'd3,
    S_CHK     = 3'd4,
    S_RELEASE = 3'd5,
    S_RUN     = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      chk_q, chk_d;
  logic [AW:0]     idx_q, idx_d;
  logic [RW-1:0]   rel_q, rel_d;
  logic            rom_we_q, rom_we_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [IW-1:0]   rom_wdata_q, rom_wdata_d;
  logic            core_start_q, core_start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            xfer_s;
  logic [15:0]     n_full_s;
  logic            last_word_s;

  // Byte acceptance depends only on the current state (and halt while running).
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_HDR_LO, S_HDR_HI, S_INS_LO, S_INS_HI, S_CHK: rx_ready = 1'b1;
      S_RUN:                                         rx_ready = halt;
      S_RELEASE, S_ERR:                              rx_ready = 1'b0;
      default:                                       rx_ready = 1'b0;
    endcase
  end

  assign xfer_s      = rx_valid & rx_ready;
  assign n_full_s    = {rx_data, cnt_q[7:0]};
  // Index is one bit wider than the address so a full 2**AW image never wraps.
  assign last_word_s = ((17'(idx_q) + 17'd1) == {1'b0, cnt_q});

  // Next-state and registered-output logic for the frame parser.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    chk_d        = chk_q;
    idx_d        = idx_q;
    rel_d        = rel_q;
    rom_we_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_wdata_d  = rom_wdata_q;
    core_start_d = core_start_q;
    done_d       = done_q;
    err_d        = err_q;
    err_code_d   = err_code_q;

    case (state_q)
      S_HDR_LO: begin
        if (xfer_s) begin
          cnt_d   = {cnt_q[15:8], rx_data};
          chk_d   = chk_q ^ rx_data;
          state_d = S_HDR_HI;
        end else begin
          state_d = S_HDR_LO;
        end
      end
      S_HDR_HI: begin
        if (xfer_s) begin
          cnt_d = n_full_s;
          chk_d = chk_q ^ rx_data;
          if ({1'b0, n_full_s} > MAX_WORDS) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else if (n_full_s == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_INS_LO;
          end
        end else begin
          state_d = S_HDR_HI;
        end
      end
      S_INS_LO: begin
        if (xfer_s) begin
          lo_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_INS_HI;
        end else begin
          state_d = S_INS_LO;
        end
      end
      S_INS_HI: begin
        if (xfer_s) begin
          chk_d = chk_q ^ rx_data;
          if (rx_data[7:1] != 7'd0) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end else begin
            rom_we_d    = 1'b1;
            rom_addr_d  = idx_q[AW-1:0];
            rom_wdata_d = IW'({rx_data[0], lo_q});
            idx_d       = idx_q + {{AW{1'b0}}, 1'b1};
            if (last_word_s) begin
              state_d = S_CHK;
            end else begin
              state_d = S_INS_LO;
            end
          end
        end else begin
          state_d = S_INS_HI;
        end
      end
      S_CHK: begin
        if (xfer_s) begin
          if (rx_data == chk_q) begin
            state_d = S_RELEASE;
            rel_d   = RW'(START_CYCLES);
          end else begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd3;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      S_RELEASE: begin
        core_start_d = 1'b1;
        if (rel_q <= RW'(1)) begin
          rel_d        = {RW{1'b0}};
          state_d      = S_RUN;
          core_start_d = 1'b0;
          done_d       = 1'b1;
        end else begin
          rel_d = rel_q - RW'(1);
        end
      end
      S_RUN: begin
        core_start_d = 1'b0;
        if (xfer_s) begin
          cnt_d        = {8'h00, rx_data};
          chk_d        = rx_data;
          idx_d        = {(AW+1){1'b0}};
          done_d       = 1'b0;
          core_start_d = 1'b1;
          state_d      = S_HDR_HI;
        end else begin
          state_d = S_RUN;
        end
      end
      S_ERR: begin
        core_start_d = 1'b1;
        err_d        = 1'b1;
        state_d      = S_ERR;
      end
      default: begin
        state_d      = S_HDR_LO;
        core_start_d = 1'b1;
      end
    endcase

    case (state_d)
      S_HDR_HI, S_INS_LO, S_INS_HI, S_CHK, S_RELEASE: busy_d = 1'b1;
      S_HDR_LO, S_RUN, S_ERR:                         busy_d = 1'b0;
      default:                                        busy_d = 1'b0;
    endcase
  end

  // State and output registers; reset leaves the core held in init.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_HDR_LO;
      cnt_q        <= 16'd0;
      lo_q         <= 8'd0;
      chk_q        <= 8'd0;
      idx_q        <= {(AW+1){1'b0}};
      rel_q        <= {RW{1'b0}};
      rom_we_q     <= 1'b0;
      rom_addr_q   <= {AW{1'b0}};
      rom_wdata_q  <= {IW{1'b0}};
      core_start_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      chk_q        <= chk_d;
      idx_q        <= idx_d;
      rel_q        <= rel_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_wdata_q  <= rom_wdata_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_wdata  = rom_wdata_q;
  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: framed loads, error frames, reload and
// a randomly gapped stream, with expected values worked out by hand.
module tb_prog_loader;

  localparam int AW = 10;
  localparam int IW = 9;

  logic          CLK;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          halt;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_wdata;
  logic          core_start;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] wr_addr[$];
  logic [IW-1:0] wr_data[$];

  prog_loader #(.AW(AW), .IW(IW), .START_CYCLES(2)) dut (
    .CLK(CLK), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .halt(halt), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .core_start(core_start), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (rom_we) begin
      wr_addr.push_back(rom_addr);
      wr_data.push_back(rom_wdata);
    end
  end

  task automatic apply_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    halt     = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    tries    = 0;
    while (!rx_ready && tries < 50) begin
      @(negedge CLK);
      tries++;
    end
    if (!rx_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%h rx_ready=%b required=1", b, rx_ready);
    end else begin
      @(posedge CLK);
    end
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL rst_core_start got=%b exp=1", core_start); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (rom_we !== 1'b0) begin failures++; $display("FAIL rst_rom_we got=%b exp=0", rom_we); end
    checks++; if (err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL rst_err got=%b/%0d exp=0/0", err, err_code); end
    checks++; if (busy !== 1'b0 || rom_addr !== 10'd0 || rom_wdata !== 9'd0) begin
      failures++; $display("FAIL rst_misc busy=%b addr=%h data=%h exp=0/0/0", busy, rom_addr, rom_wdata); end
  endtask

  task automatic test_load();
    logic [7:0] frame[7];
    frame = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9A};
    apply_reset();
    for (int i = 0; i < 7; i++) send_byte(frame[i], 0);
    checks++; if (core_start !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL load_rel1 cs=%b busy=%b done=%b exp=1/1/0", core_start, busy, done); end
    @(posedge CLK); #1;
    checks++; if (core_start !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL load_rel2 cs=%b done=%b exp=1/0", core_start, done); end
    @(posedge CLK); #1;
    checks++; if (core_start !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL load_run cs=%b done=%b busy=%b exp=0/1/0", core_start, done, busy); end
    checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL load_wr_count got=%0d exp=2", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 9'h1A5) begin
        failures++; $display("FAIL load_wr0 got=%h:%h exp=000:1a5", wr_addr[0], wr_data[0]); end
      checks++; if (wr_addr[1] !== 10'd1 || wr_data[1] !== 9'h03C) begin
        failures++; $display("FAIL load_wr1 got=%h:%h exp=001:03c", wr_addr[1], wr_data[1]); end
    end
  endtask

  task automatic test_halt_reload();
    logic [7:0] frame[5];
    frame = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'hFF};
    halt = 1'b0;
    @(negedge CLK);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (rx_ready !== 1'b0 || done !== 1'b1 || core_start !== 1'b0) begin
      failures++; $display("FAIL halt_block rdy=%b done=%b cs=%b exp=0/1/0", rx_ready, done, core_start); end
    rx_valid = 1'b0;
    halt     = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    send_byte(frame[0], 0);
    checks++; if (done !== 1'b0 || core_start !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL reload_start done=%b cs=%b busy=%b exp=0/1/1", done, core_start, busy); end
    for (int i = 1; i < 5; i++) send_byte(frame[i], 0);
    repeat (3) @(posedge CLK); #1;
    checks++; if (done !== 1'b1 || core_start !== 1'b0) begin
      failures++; $display("FAIL reload_done done=%b cs=%b exp=1/0", done, core_start); end
    checks++; if (wr_addr.size() !== 1 || wr_addr[0] !== 10'd0 || wr_data[0] !== 9'h1FF) begin
      failures++; $display("FAIL reload_wr n=%0d exp=1 addr0:data0 exp=000:1ff", wr_addr.size()); end
    halt = 1'b0;
  endtask

  task automatic test_err_high();
    apply_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h11, 0); send_byte(8'h02, 0);
    checks++; if (err !== 1'b1 || err_code !== 2'd2) begin
      failures++; $display("FAIL errhi_code err=%b code=%0d exp=1/2", err, err_code); end
    checks++; if (rx_ready !== 1'b0 || core_start !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL errhi_outs rdy=%b cs=%b busy=%b exp=0/1/0", rx_ready, core_start, busy); end
    rx_valid = 1'b1;
    repeat (3) @(negedge CLK);
    rx_valid = 1'b0;
    checks++; if (wr_addr.size() !== 0 || err_code !== 2'd2) begin
      failures++; $display("FAIL errhi_nowrite writes=%0d code=%0d exp=0/2", wr_addr.size(), err_code); end
  endtask

  task automatic test_err_count();
    apply_reset();
    send_byte(8'h01, 0); send_byte(8'h04, 0);
    repeat (2) @(negedge CLK);
    checks++; if (err !== 1'b1 || err_code !== 2'd1 || wr_addr.size() !== 0) begin
      failures++; $display("FAIL errcnt err=%b code=%0d writes=%0d exp=1/1/0", err, err_code, wr_addr.size()); end
  endtask

  task automatic test_empty();
    apply_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    repeat (3) @(posedge CLK); #1;
    checks++; if (done !== 1'b1 || err !== 1'b0 || wr_addr.size() !== 0) begin
      failures++; $display("FAIL empty_ok done=%b err=%b writes=%0d exp=1/0/0", done, err, wr_addr.size()); end
    apply_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'hFF, 0);
    @(negedge CLK);
    checks++; if (err !== 1'b1 || err_code !== 2'd3 || done !== 1'b0 || core_start !== 1'b1) begin
      failures++; $display("FAIL empty_badchk err=%b code=%0d done=%b cs=%b exp=1/3/0/1", err, err_code, done, core_start); end
  endtask

  task automatic test_random_valid();
    logic [7:0] frame[7];
    frame = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9A};
    apply_reset();
    send_byte(8'h05, 1); send_byte(8'h00, 2);
    apply_reset();
    checks++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin
      failures++; $display("FAIL midreset busy=%b rdy=%b exp=0/1", busy, rx_ready); end
    for (int i = 0; i < 7; i++) send_byte(frame[i], int'($urandom_range(0, 3)));
    repeat (3) @(posedge CLK); #1;
    checks++; if (done !== 1'b1 || core_start !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL rnd_done done=%b cs=%b err=%b exp=1/0/0", done, core_start, err); end
    checks++; if (wr_addr.size() !== 2 || wr_data[0] !== 9'h1A5 || wr_data[1] !== 9'h03C || wr_addr[1] !== 10'd1) begin
      failures++; $display("FAIL rnd_writes n=%0d exp=2 data exp=1a5,03c", wr_addr.size()); end
  endtask

  task automatic test_max_image();
    logic [7:0] chk;
    int bad;
    apply_reset();
    chk = 8'h00 ^ 8'h04;
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] v;
      v = 10'(i);
      send_byte(v[7:0], 0);
      send_byte({7'd0, v[8]}, 0);
      chk = chk ^ v[7:0] ^ {7'd0, v[8]};
    end
    send_byte(chk, 0);
    repeat (3) @(posedge CLK); #1;
    checks++; if (done !== 1'b1 || err !== 1'b0) begin
      failures++; $display("FAIL max_done done=%b err=%b code=%0d exp=1/0", done, err, err_code); end
    bad = 0;
    if (wr_addr.size() == 1024) begin
      for (int i = 0; i < 1024; i++) begin
        logic [9:0] v;
        v = 10'(i);
        if (wr_addr[i] !== v || wr_data[i] !== v[8:0]) bad++;
      end
    end else begin
      bad = 1;
    end
    checks++; if (bad !== 0) begin
      failures++; $display("FAIL max_writes n=%0d exp=1024 bad=%0d exp=0", wr_addr.size(), bad); end
    checks++; if (rom_addr !== 10'h3FF || rom_wdata !== 9'h1FF) begin
      failures++; $display("FAIL max_last addr=%h data=%h exp=3ff/1ff", rom_addr, rom_wdata); end
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    halt     = 1'b0;
    test_reset();
    test_load();
    test_halt_reload();
    test_err_high();
    test_err_count();
    test_empty();
    test_random_valid();
    test_max_image();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
